// File: rtl/note_to_dds_increment_pkg.sv
// Shared widths, clock constant and types for the MIDI-note to DDS phase-increment lookup.
package note_to_dds_increment_pkg;

  localparam int NOTE_W     = 7;
  localparam int ADDER_W    = 32;
  localparam int DDS_CLK_HZ = 50_000_000;
  localparam int ROM_DEPTH  = 1 << NOTE_W;

  typedef logic [NOTE_W-1:0]  note_t;
  typedef logic [ADDER_W-1:0] dds_inc_t;

  // Synthesised output frequency in millihertz for a given increment (debug aid).
  function automatic logic [63:0] inc_to_millihz(dds_inc_t inc);
    return (64'(inc) * 64'(DDS_CLK_HZ) * 64'd1000) >> ADDER_W;
  endfunction

endpackage

// File: rtl/note_to_dds_increment_if.sv
// Note-in / increment-out bundle between the pitch-wheel interpolator and the lookup.
interface note_to_dds_increment_if;
  import note_to_dds_increment_pkg::*;

  note_t    note;
  dds_inc_t adder;

  modport master (output note, input adder);
  modport slave  (input note, output adder);

endinterface

// File: rtl/note_inc_rom.sv
// Combinational 128x32 table: entry n = round_half_up(2^32 * 440 * 2^((n-69)/12) / 50e6).
module note_inc_rom
  import note_to_dds_increment_pkg::*;
(
  input  note_t    note,
  output dds_inc_t inc
);

  localparam dds_inc_t INC_TABLE [ROM_DEPTH] = '{
    32'd702,
    32'd744,
    32'd788,
    32'd835,
    32'd885,
    32'd937,
    32'd993,
    32'd1052,
    32'd1115,
    32'd1181,
    32'd1251,
    32'd1326,
    32'd1405,
    32'd1488,
    32'd1577,
    32'd1670,
    32'd1770,
    32'd1875,
    32'd1986,
    32'd2105,
    32'd2230,
    32'd2362,
    32'd2503,
    32'd2652,
    32'd2809,
    32'd2976,
    32'd3153,
    32'd3341,
    32'd3539,
    32'd3750,
    32'd3973,
    32'd4209,
    32'd4459,
    32'd4724,
    32'd5005,
    32'd5303,
    32'd5618,
    32'd5952,
    32'd6306,
    32'd6681,
    32'd7079,
    32'd7500,
    32'd7946,
    32'd8418,
    32'd8919,
    32'd9449,
    32'd10011,
    32'd10606,
    32'd11237,
    32'd11905,
    32'd12613,
    32'd13363,
    32'd14157,
    32'd14999,
    32'd15891,
    32'd16836,
    32'd17837,
    32'd18898,
    32'd20022,
    32'd21212,
    32'd22473,
    32'd23810,
    32'd25226,
    32'd26726,
    32'd28315,
    32'd29998,
    32'd31782,
    32'd33672,
    32'd35674,
    32'd37796,
    32'd40043,
    32'd42424,
    32'd44947,
    32'd47620,
    32'd50451,
    32'd53451,
    32'd56630,
    32'd59997,
    32'd63565,
    32'd67344,
    32'd71349,
    32'd75591,
    32'd80086,
    32'd84849,
    32'd89894,
    32'd95239,
    32'd100902,
    32'd106902,
    32'd113259,
    32'd119994,
    32'd127129,
    32'd134689,
    32'd142698,
    32'd151183,
    32'd160173,
    32'd169697,
    32'd179788,
    32'd190478,
    32'd201805,
    32'd213805,
    32'd226518,
    32'd239988,
    32'd254258,
    32'd269377,
    32'd285395,
    32'd302366,
    32'd320345,
    32'd339394,
    32'd359575,
    32'd380957,
    32'd403610,
    32'd427610,
    32'd453037,
    32'd479976,
    32'd508516,
    32'd538754,
    32'd570790,
    32'd604731,
    32'd640691,
    32'd678788,
    32'd719151,
    32'd761914,
    32'd807220,
    32'd855219,
    32'd906073,
    32'd959951,
    32'd1017033,
    32'd1077509
  };

  // The 7-bit note spans the whole table, so no range guard is needed.
  assign inc = INC_TABLE[note];

endmodule

// File: rtl/note_to_dds_increment.sv
// One-cycle-latency note-to-increment lookup; output comes straight from a flop.
module note_to_dds_increment
  import note_to_dds_increment_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  note_to_dds_increment_if.slave   bus
);

  dds_inc_t rom_inc;
  dds_inc_t adder_reg;

  note_inc_rom u_rom (
    .note (bus.note),
    .inc  (rom_inc)
  );

  // Reset clears the output immediately so no stale pitch survives a mid-stream reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_reg <= '0;
    end else begin
      adder_reg <= rom_inc;
    end
  end

  assign bus.adder = adder_reg;

endmodule

// File: tb/tb_note_to_dds_increment.sv
// Self-checking bench: spot-value table, full sweep, octave ratio, interpolator pattern, random and async reset.
module tb_note_to_dds_increment;
  import note_to_dds_increment_pkg::*;

  typedef struct {
    int     note;
    longint adder;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  note_to_dds_increment_if bus ();

  note_to_dds_increment dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: the frequency formula evaluated in double precision, rounded half-up.
  function automatic longint ref_inc(int n);
    real f;
    real x;
    f = 440.0 * (2.0 ** (real'(n - 69) / 12.0));
    x = 4294967296.0 * f / 50000000.0;
    return longint'($floor(x + 0.5));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint got, input longint req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: adder=%0d required=%0d", name, got, req);
    end else begin
      $display("ok   %s: adder=%0d", name, got);
    end
  endtask

  task automatic check_range(input string name, input longint got, input longint lo, input longint hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: value=%0d required %0d..%0d", name, got, lo, hi);
    end else begin
      $display("ok   %s: value=%0d in %0d..%0d", name, got, lo, hi);
    end
  endtask

  initial begin
    vec_t   vecs [7];
    longint sweep_got [128];
    longint prev;
    int     cur;

    vecs = '{'{69, 37796}, '{57, 18898}, '{81, 75591}, '{60, 22473},
             '{0, 702}, '{61, 23810}, '{127, 1077509}};

    // Reset held with note 69 applied.
    rst_n    = 1'b0;
    bus.note = note_t'(69);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", longint'(bus.adder), 0);
    end
    rst_n = 1'b1;
    #2;
    check("release_before_edge", longint'(bus.adder), 0);
    step();
    check("release_first_edge", longint'(bus.adder), 37796);

    // Spot values from the table.
    for (int i = 0; i < 7; i++) begin
      bus.note = note_t'(vecs[i].note);
      step();
      check($sformatf("spot_note_%0d", vecs[i].note), longint'(bus.adder), vecs[i].adder);
    end

    // Back-to-back sweep 0..127.
    prev = 0;
    for (int k = 0; k < 128; k++) begin
      bus.note = note_t'(k);
      step();
      sweep_got[k] = longint'(bus.adder);
      check($sformatf("sweep_note_%0d", k), sweep_got[k], ref_inc(k));
      if (k > 0) begin
        check_range($sformatf("sweep_increasing_%0d", k), sweep_got[k], prev + 1, 64'hFFFF_FFFF);
      end
      prev = sweep_got[k];
    end

    // Octave ratio over the swept outputs.
    for (int n = 0; n < 116; n++) begin
      check_range($sformatf("octave_%0d", n), sweep_got[n + 12],
                  2 * sweep_got[n] - 1, 2 * sweep_got[n] + 1);
    end

    // Interpolator pattern N, N+1, N+1.
    bus.note = note_t'(60);
    step();
    check("interp_0", longint'(bus.adder), 22473);
    bus.note = note_t'(61);
    step();
    check("interp_1", longint'(bus.adder), 23810);
    step();
    check("interp_2", longint'(bus.adder), 23810);

    // Random notes with junk toggles between edges; only the edge value counts.
    for (int i = 0; i < 200; i++) begin
      cur      = int'($urandom_range(127));
      bus.note = note_t'($urandom_range(127));
      #2;
      bus.note = note_t'($urandom_range(127));
      #2;
      bus.note = note_t'(cur);
      step();
      check($sformatf("rand_note_%0d", cur), longint'(bus.adder), ref_inc(cur));
    end

    // Async reset asserted between edges during a sweep.
    for (int k = 20; k < 24; k++) begin
      bus.note = note_t'(k);
      step();
      check($sformatf("pre_reset_note_%0d", k), longint'(bus.adder), ref_inc(k));
    end
    bus.note = note_t'(24);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", longint'(bus.adder), 0);
    step();
    check("async_reset_held", longint'(bus.adder), 0);
    bus.note = note_t'(100);
    #2;
    rst_n = 1'b1;
    step();
    check("reset_refill_note_100", longint'(bus.adder), ref_inc(100));
    bus.note = note_t'(101);
    step();
    check("reset_refill_note_101", longint'(bus.adder), ref_inc(101));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
